// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - states, LCD command bytes and geometry shared by the frame feeder
package lcd_pkg;

   typedef enum logic [2:0] {
      INIT_HI,
      INIT_LO,
      IDLE,
      FETCH,
      ISSUE,
      ACK,
      DONE
   } feeder_state_t;

   localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
   localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
   localparam int         LCD_COLS      = 16;
   localparam int         LCD_CELLS     = 32;

   // Set-DDRAM-address command that places the cursor on a given cell.
   function automatic logic [7:0] cursor_cmd(input logic [4:0] pos);
      return (pos[4] ? LCD_CMD_LINE2 : LCD_CMD_LINE1) + {4'd0, pos[3:0]};
   endfunction

endpackage

// File: rtl/lcd_frame_ram.sv
// rtl/lcd_frame_ram.sv - 32x8 character buffer, synchronous write and read ports
// Cells power up holding CHAR_RESET; reset never touches the contents.
module lcd_frame_ram #(
   parameter logic [7:0] CHAR_RESET = 8'h20
) (
   input  logic       clock,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data
);
   import lcd_pkg::*;

   logic [7:0] mem [LCD_CELLS] = '{default: CHAR_RESET};

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/lcd_frame_feeder.sv
// rtl/lcd_frame_feeder.sv - streams the 32-cell frame buffer to the HD44780 OLED driver
// Optional LCD_FEEDER_CURSOR_EN appends a cursor-placement command as the final item.
module lcd_frame_feeder #(
   parameter logic [7:0] CHAR_RESET = 8'h20
) (
   input  logic       clock,
   input  logic       internal_reset,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       refresh,
   input  logic [4:0] cursor_pos,
   input  logic       busy_flag,
   output logic [8:0] d_in,
   output logic       data_ready,
   output logic       frame_busy
);
   import lcd_pkg::*;

   localparam logic [5:0] LINE2_ITEM = 6'(LCD_COLS + 1);
`ifdef LCD_FEEDER_CURSOR_EN
   localparam logic [5:0] LAST_ITEM  = 6'(2 * LCD_COLS + 2);
`else
   localparam logic [5:0] LAST_ITEM  = 6'(2 * LCD_COLS + 1);
`endif

   feeder_state_t state;
   logic [5:0]    item;
   logic          pending;
   logic [4:0]    rd_addr;
   logic [7:0]    rd_data;
   logic [8:0]    word;

   // Items 1-16 map to cells 0-15, items 18-33 to cells 16-31 (mod-32 wrap does the rest).
   assign rd_addr = (item <= 6'(LCD_COLS)) ? (item[4:0] - 5'd1) : (item[4:0] - 5'd2);

   lcd_frame_ram #(.CHAR_RESET(CHAR_RESET)) u_ram (
      .clock   (clock),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

`ifdef LCD_FEEDER_CURSOR_EN
   logic [7:0] cursor_word;
`else
   logic unused_cursor;
   assign unused_cursor = ^cursor_pos;
`endif

   always_comb begin
      word = {1'b1, rd_data};
      if (item == 6'd0) begin
         word = {1'b0, LCD_CMD_LINE1};
      end else if (item == LINE2_ITEM) begin
         word = {1'b0, LCD_CMD_LINE2};
      end
`ifdef LCD_FEEDER_CURSOR_EN
      else if (item == LAST_ITEM) begin
         word = {1'b0, cursor_word};
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (internal_reset) begin
         state      <= INIT_HI;
         item       <= 6'd0;
         pending    <= 1'b0;
         d_in       <= 9'd0;
         data_ready <= 1'b0;
         frame_busy <= 1'b1;
      end else begin
         data_ready <= 1'b0;
         case (state)
            INIT_HI: if (busy_flag) state <= INIT_LO;
            INIT_LO: begin
               if (!busy_flag) begin
                  state      <= IDLE;
                  frame_busy <= pending | refresh;
               end
            end
            IDLE: begin
               if (refresh || pending) begin
                  pending    <= 1'b0;
                  item       <= 6'd0;
                  frame_busy <= 1'b1;
                  state      <= FETCH;
               end
            end
            FETCH: begin
`ifdef LCD_FEEDER_CURSOR_EN
               cursor_word <= cursor_cmd(cursor_pos);
`endif
               state <= ISSUE;
            end
            ISSUE: begin
               if (!busy_flag) begin
                  d_in       <= word;
                  data_ready <= 1'b1;
                  state      <= ACK;
               end
            end
            ACK: if (busy_flag) state <= DONE;
            DONE: begin
               if (!busy_flag) begin
                  if (item != LAST_ITEM) begin
                     item  <= item + 6'd1;
                     state <= FETCH;
                  end else if (pending) begin
                     pending <= 1'b0;
                     item    <= 6'd0;
                     state   <= FETCH;
                  end else begin
                     frame_busy <= 1'b0;
                     state      <= IDLE;
                  end
               end
            end
            default: state <= INIT_HI;
         endcase
         // Requests arriving while busy are remembered; these override the clears above.
         if ((state inside {INIT_HI, INIT_LO}) && refresh) begin
            pending <= 1'b1;
         end
         if ((state inside {FETCH, ISSUE, ACK, DONE}) && (refresh || wr_en)) begin
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lcd_frame_feeder.sv
// tb/tb_lcd_frame_feeder.sv - randomized self-checking bench with an LCD driver model
// Define LCD_FEEDER_CURSOR_EN to exercise the cursor item.
`timescale 1ns/1ps
module tb_lcd_frame_feeder;

   logic       clock          = 1'b0;
   logic       internal_reset = 1'b1;
   logic       wr_en          = 1'b0;
   logic [4:0] wr_addr        = 5'd0;
   logic [7:0] wr_data        = 8'd0;
   logic       refresh        = 1'b0;
   logic [4:0] cursor_pos     = 5'd0;
   logic       busy_flag      = 1'b0;
   logic [8:0] d_in;
   logic       data_ready;
   logic       frame_busy;

   int n_checks = 0;
   int n_fails  = 0;

   logic [7:0] ref_buf [32];
   logic [8:0] cap   [$];
   logic [8:0] exp_q [$];

   int         busy_max    = 4;
   int         pulses      = 0;
   int         init_cnt    = 0;
   int         busy_cnt    = 0;
   bit         start_latch = 1'b0;
   bit         hold_open   = 1'b0;
   bit         hold_ok     = 1'b0;
   logic [8:0] hold_val    = 9'd0;

   lcd_frame_feeder dut (
      .clock          (clock),
      .internal_reset (internal_reset),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .refresh        (refresh),
      .cursor_pos     (cursor_pos),
      .busy_flag      (busy_flag),
      .d_in           (d_in),
      .data_ready     (data_ready),
      .frame_busy     (frame_busy)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // Driver model: 100-cycle power-on busy after reset, then per item a start latch,
   // busy set, and a busy period of 2..busy_max cycles.
   always @(negedge clock) begin
      if (internal_reset) begin
         busy_flag   = 1'b0;
         start_latch = 1'b0;
         busy_cnt    = 0;
         init_cnt    = 100;
         hold_open   = 1'b0;
      end else begin
         if (data_ready) begin
            check_eq("dr_while_busy", busy_flag, 0);
            cap.push_back(d_in);
            pulses++;
            hold_val  = d_in;
            hold_ok   = 1'b1;
            hold_open = 1'b1;
         end else if (hold_open) begin
            if (d_in !== hold_val) hold_ok = 1'b0;
            if (busy_flag) begin
               check_eq("d_in_hold", hold_ok, 1);
               hold_open = 1'b0;
            end
         end
         if (init_cnt > 0) begin
            init_cnt--;
            busy_flag = (init_cnt != 0);
         end else if (busy_flag) begin
            if (busy_cnt <= 1) busy_flag = 1'b0;
            else busy_cnt--;
         end else if (start_latch) begin
            busy_flag   = 1'b1;
            busy_cnt    = $urandom_range(busy_max, 2);
            start_latch = 1'b0;
         end
         if (data_ready) start_latch = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_cell(input int a, input logic [7:0] v);
      wr_en   = 1'b1;
      wr_addr = a[4:0];
      wr_data = v;
      ref_buf[a] = v;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
   endtask

   function automatic void add_frame();
      exp_q.push_back(9'h080);
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, ref_buf[i]});
      exp_q.push_back(9'h0C0);
      for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, ref_buf[i]});
`ifdef LCD_FEEDER_CURSOR_EN
      if (cursor_pos < 16) exp_q.push_back(9'h080 + 9'(cursor_pos));
      else exp_q.push_back(9'h0C0 + 9'(cursor_pos) - 9'd16);
`endif
   endfunction

   task automatic wait_idle(input string tag);
      int n = 0;
      while (frame_busy && n < 12000) begin
         @(negedge clock);
         n++;
      end
      check_eq({tag, "_idle"}, frame_busy, 0);
      repeat (20) tick();
   endtask

   task automatic wait_pulses(input int target, input string tag);
      int n = 0;
      while (cap.size() < target && n < 12000) begin
         tick();
         n++;
      end
      check_eq({tag, "_reached"}, (cap.size() >= target), 1);
   endtask

   task automatic compare_frames(input string tag);
      check_eq({tag, "_count"}, cap.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
         check_eq($sformatf("%s_item%0d", tag, i), cap[i], exp_q[i]);
      end
      cap.delete();
      exp_q.delete();
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int p0;
      int fb_low;
      int n;
      logic [7:0] newv;

      foreach (ref_buf[i]) ref_buf[i] = 8'h20;

      // Reset state
      repeat (3) tick();
      @(negedge clock);
      check_eq("rst_d_in", d_in, 0);
      check_eq("rst_data_ready", data_ready, 0);
      check_eq("rst_frame_busy", frame_busy, 1);
      tick();
      internal_reset = 1'b0;

      // Power-up: refresh arrives during driver initialisation and is held pending
      repeat (10) tick();
      pulse_refresh();
      @(negedge clock);
      check_eq("init_frame_busy", frame_busy, 1);
      check_eq("init_no_pulse", pulses, 0);
      tick();
      add_frame();
      wait_idle("power_up");
      compare_frames("power_up");

      // Write-then-stream
      write_cell(0, 8'h31);
      write_cell(31, 8'h39);
      pulse_refresh();
      add_frame();
      wait_idle("write");
      check_eq("write_item1", (cap.size() > 1) ? cap[1] : 9'd0, 9'h131);
      check_eq("write_item33", (cap.size() > 33) ? cap[33] : 9'd0, 9'h139);
      compare_frames("write");

      // Random contents with long randomized busy periods
      busy_max = 200;
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 6; k++) write_cell($urandom_range(31, 0), 8'($urandom));
         cursor_pos = 5'($urandom_range(31, 0));
         pulse_refresh();
         add_frame();
         wait_idle($sformatf("rand%0d", f));
         compare_frames($sformatf("rand%0d", f));
      end
      busy_max = 4;
      cursor_pos = 5'd0;

      // Write to cell 5 while item 10 is in flight: old frame completes, new one follows
      pulse_refresh();
      add_frame();
      wait_pulses(10, "midwr");
      newv = (ref_buf[5] == 8'hA5) ? 8'h5A : 8'hA5;
      write_cell(5, newv);
      add_frame();
      fb_low = 0;
      n = 0;
      while (cap.size() < 68 && n < 12000) begin
         tick();
         n++;
         if (!frame_busy) fb_low++;
      end
      check_eq("midwr_frame_busy_low", fb_low, 0);
      wait_idle("midwr");
      check_eq("midwr_item6_f2", (cap.size() > 40) ? cap[40] : 9'd0, {1'b1, newv});
      compare_frames("midwr");

      // Reset at item 20
      pulse_refresh();
      wait_pulses(20, "midrst");
      internal_reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_eq("midrst_data_ready", data_ready, 0);
      check_eq("midrst_frame_busy", frame_busy, 1);
      p0 = pulses;
      tick();
      internal_reset = 1'b0;
      wait_idle("midrst_init");
      check_eq("midrst_no_issue", pulses, p0);
      cap.delete();
      exp_q.delete();
      pulse_refresh();
      add_frame();
      wait_idle("recover");
      compare_frames("recover");

`ifdef LCD_FEEDER_CURSOR_EN
      cursor_pos = 5'd18;
      pulse_refresh();
      add_frame();
      wait_idle("cur18");
      check_eq("cur18_count", cap.size(), 35);
      check_eq("cur18_last", (cap.size() > 0) ? cap[$] : 9'd0, 9'h0C2);
      compare_frames("cur18");
      cursor_pos = 5'd3;
      pulse_refresh();
      add_frame();
      wait_idle("cur3");
      check_eq("cur3_last", (cap.size() > 0) ? cap[$] : 9'd0, 9'h083);
      compare_frames("cur3");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/lcd_frame_feeder.md
# lcd_frame_feeder

Upstream feeder for the HD44780-compatible 16x2 OLED driver. Holds a 32-character frame buffer that the calculator logic writes by address, and on request streams the frame to the driver's `d_in`/`data_ready`/`busy_flag` handshake. Each streamed frame is: the line-1 address command, 16 characters, the line-2 address command, then 16 characters. The calculator core never sequences LCD commands itself.

## Interface
- `CHAR_RESET`, default 8'h20: power-up content of every buffer cell (space).
- `clock`  in  1  system clock, shared with the LCD driver.
- `internal_reset`  in  1  synchronous, active-high reset, shared with the LCD driver.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  5  cell index; 0–15 are line 1, 16–31 are line 2.
- `wr_data`  in  8  character code.
- `refresh`  in  1  single-cycle request to stream the frame.
- `cursor_pos`  in  5  final cursor cell; only used with `LCD_FEEDER_CURSOR_EN`.
- `busy_flag`  in  1  from the LCD driver.
- `d_in`  out  9  to the LCD driver; bit 8 = RS (1 = character, 0 = command), bits 7:0 = byte.
- `data_ready`  out  1  single-cycle strobe to the LCD driver.
- `frame_busy`  out  1  high while initialising, streaming, or holding a pending refresh.

## Operation
- Reset values: `d_in`=0, `data_ready`=0, `frame_busy`=1, state=INIT_HI, item=0, pending=0. Reset does not clear buffer contents; power-up content is `CHAR_RESET` in every cell.
- Writes go into the buffer at any time, in any state, with single-cycle effect.
- INIT_HI: wait for `busy_flag`=1, meaning the driver has started its power-on initialisation.
- INIT_LO: wait for `busy_flag`=0. Then clear `frame_busy` and go to IDLE.
- IDLE:
  - On `refresh` or pending: clear pending, set item=0, set `frame_busy`=1, go to FETCH.
  - Otherwise stay in IDLE.
- Item map:
  - item 0 → command 0x080.
  - items 1–16 → characters `{1'b1, buf[item-1]}`.
  - item 17 → command 0x0C0.
  - items 18–33 → characters `{1'b1, buf[item-2]}`.
- FETCH: drive the buffer read address. The read data is valid on the next cycle. Go to ISSUE.
- ISSUE: when `busy_flag`=0, latch `d_in`, pulse `data_ready` for one cycle, and go to ACK.
- ACK: hold `d_in` stable and wait for `busy_flag`=1. The driver latches `d_in` in this window.
- DONE: wait for `busy_flag`=0. Then:
  - If more items remain, increment item and go to FETCH.
  - After the last item, go to IDLE and clear `frame_busy`, unless pending is set.
- `refresh` or `wr_en` asserted outside IDLE/INIT sets pending. The frame in flight completes unchanged, and a full re-stream follows immediately. A write during streaming may or may not appear in the current frame; it always appears in the following frame.
- `refresh` during INIT_HI/INIT_LO sets pending. It is serviced on entry to IDLE.
- Reset mid-frame: the block returns to INIT_HI at once, with no partial handshake kept. The driver resets in the same cycle.

## Timing
- `busy_flag` rises two cycles after `data_ready`: the driver's start latch, then its busy set.
- `d_in` must not change between the `data_ready` cycle and the first ACK cycle that sees `busy_flag`=1.
- Per-item overhead outside driver busy time: FETCH 1 + ISSUE 1 + ACK ≥2 + DONE exit 1 cycles.
- `data_ready` is never high for two consecutive cycles and never high while `busy_flag`=1.
- Frame length is 34 handshakes, or 35 with the cursor feature.

## Configuration
- `LCD_FEEDER_CURSOR_EN` defined: add item 34, the command `{1'b0, cursor_pos<16 ? 8'h80+cursor_pos : 8'hC0+(cursor_pos-16)}`. `cursor_pos` is sampled when the item is fetched.
- Undefined: the frame ends at item 33, `cursor_pos` is ignored, and the visible cursor is left after cell 31.

## Structure
- Package `lcd_pkg` holds:
  - the state enum (INIT_HI, INIT_LO, IDLE, FETCH, ISSUE, ACK, DONE);
  - constants `LCD_CMD_LINE1`=8'h80 and `LCD_CMD_LINE2`=8'hC0;
  - `LCD_COLS`=16 and `LCD_CELLS`=32.
- Sub-module `lcd_frame_ram`: 32x8, one synchronous write port and one synchronous read port, initialised to `CHAR_RESET`.
- Top level: FSM, item counter, pending flag, and output registers.

## Test plan
- Power-up streaming:
  - Stimulus: reset, the driver model holds `busy_flag` high for 100 cycles and then low; `refresh` is pulsed.
  - Required response: 34 `data_ready` pulses.
  - Captured `d_in` sequence: 0x080, 16×0x120, 0x0C0, 16×0x120.
- Write-then-stream:
  - Stimulus: write 0x31 to cell 0 and 0x39 to cell 31, then `refresh`.
  - Required response: the item 1 word is 0x131 and the item 33 word is 0x139.
- Handshake integrity:
  - Stimulus: driver model with a randomized busy length of 2–200 cycles.
  - Required response: `d_in` is constant from `data_ready` until `busy_flag` rises, and `data_ready` is never high with `busy_flag`=1.
- Refresh/write during a frame:
  - Stimulus: `wr_en` to cell 5 at item 10.
  - Required response: exactly 68 pulses in total, `frame_busy` stays high throughout, and the second frame carries the new cell 5 value.
- Reset mid-frame:
  - Stimulus: assert `internal_reset` at item 20.
  - Required response: `data_ready` is 0 and `frame_busy` is 1 the next cycle, and nothing is issued until the INIT_HI/INIT_LO sequence completes.
- With `LCD_FEEDER_CURSOR_EN`:
  - `cursor_pos`=18 → last word 0x0C2, 35 pulses.
  - `cursor_pos`=3 → last word 0x083.
